// File: rtl/countdown_ctrl.sv
// MM:SS countdown controller: BCD digit entry, confirm, start/pause,
// and 1 Hz decrement, with registered display/state outputs.
module countdown_ctrl #(
    parameter logic [15:0] DEFAULT_TIME = 16'h0100,
    parameter bit          CLAMP_SEC    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keydown_start,
    input  logic        keydown_confirm,
    input  logic        keydown_clear,
    input  logic        keydown_num,
    input  logic [3:0]  num,
    input  logic        tick,
    output logic [15:0] display,
    output logic [2:0]  state,
    output logic        running,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        EDIT    = 3'd0,
        ARMED   = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [15:0] time_q, time_d;
    logic [15:0] saved_q, saved_d;
    logic [15:0] disp_d;
    logic        done_d, err_d;
    logic        k_clr, k_start, k_conf, k_num;
    logic        sec_bad;
    logic [15:0] confirmed;

    // One BCD second down; borrows ripple S0 -> S1 -> M0 -> M1.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Only the highest-priority key survives; out-of-range digits never count.
    always_comb begin
        k_clr     = keydown_clear;
        k_start   = keydown_start & ~keydown_clear;
        k_conf    = keydown_confirm & ~keydown_clear & ~keydown_start;
        k_num     = keydown_num & (num <= 4'd9) & ~keydown_clear
                    & ~keydown_start & ~keydown_confirm;
        sec_bad   = entry_q[7:4] > 4'd5;
        confirmed = sec_bad ? {entry_q[15:8], 8'h59} : entry_q;
    end

    // Next-state, entry/time updates and output pulses.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        time_d  = time_q;
        saved_d = saved_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            EDIT: begin
                if (k_clr) begin
                    entry_d = 16'h0000;
                end else if (k_conf) begin
                    if (sec_bad && !CLAMP_SEC) begin
                        err_d = 1'b1;
                    end else begin
                        time_d  = confirmed;
                        saved_d = confirmed;
                        state_d = ARMED;
                    end
                end else if (k_num) begin
                    entry_d = {entry_q[11:0], num};
                end
            end
            ARMED: begin
                if (k_clr) begin
                    entry_d = 16'h0000;
                    state_d = EDIT;
                end else if (k_start) begin
                    if (time_q != 16'h0000) state_d = RUNNING;
                end else if (k_num) begin
                    entry_d = {12'h000, num};
                    state_d = EDIT;
                end
            end
            RUNNING: begin
                if (k_clr) begin
                    entry_d = 16'h0000;
                    state_d = EDIT;
                end else if (k_start) begin
                    state_d = PAUSED;
                end else if (tick && time_q != 16'h0000) begin
                    time_d = bcd_dec(time_q);
                    if (time_q == 16'h0001) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (k_clr) begin
                    entry_d = 16'h0000;
                    state_d = EDIT;
                end else if (k_start) begin
                    state_d = RUNNING;
                end
            end
            DONE: begin
                if (k_clr) begin
                    entry_d = 16'h0000;
                    state_d = EDIT;
                end else if (k_start) begin
                    time_d  = saved_q;
                    state_d = ARMED;
                end
            end
            default: begin
                entry_d = 16'h0000;
                state_d = EDIT;
            end
        endcase
        if (state_d == EDIT)      disp_d = entry_d;
        else if (state_d == DONE) disp_d = 16'h0000;
        else                      disp_d = time_d;
    end

    // State and datapath registers, plus registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EDIT;
            entry_q <= 16'h0000;
            time_q  <= DEFAULT_TIME;
            saved_q <= DEFAULT_TIME;
            display <= 16'h0000;
            running <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            time_q  <= time_d;
            saved_q <= saved_d;
            display <= disp_d;
            running <= (state_d == RUNNING);
            done    <= done_d;
            err     <= err_d;
        end
    end

    assign state = state_q;

endmodule
